// File: rtl/csi_pkg.sv
// csi_pkg: shared types and default sizing for the CSI line-buffer controller
package csi_pkg;
    typedef enum logic [1:0] {BUF_EMPTY, BUF_FILL, BUF_FULL, BUF_DRAIN} buf_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_STREAM, RD_FLUSH} rd_state_t;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_ADDR_W = 16;
endpackage

// File: rtl/csi_skid_fifo.sv
// csi_skid_fifo: two-entry FIFO decoupling line-buffer reads from stream backpressure
module csi_skid_fifo #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] tail;
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop && count == 2'd2) dout <= tail;
            if (push) begin
                if (count == 2'd0 || (count == 2'd1 && pop)) dout <= din;
                else tail <= din;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/csi_linebuf_ctrl.sv
// csi_linebuf_ctrl: ping-pong line-buffer controller feeding an AXI4-Stream master
module csi_linebuf_ctrl
    import csi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic              wr_line_end,
    input  logic              wr_frame_start,
    output logic              we,
    output logic              line_select,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_select,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              Tready,
    output logic              Tvalid_out,
    output logic [DATA_W-1:0] Tdata,
    output logic              Tuser,
    output logic              Tlast,
    output logic              overflow,
    output logic [CNT_W-1:0]  ovf_count
);
    localparam logic [ADDR_W:0] ONE     = 1;
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH;
    buf_state_t      bstate [2];
    logic [ADDR_W:0] blen [2];
    logic            sof_flag [2];
    logic            wp, rp, sof_pending, dropping;
    logic [ADDR_W:0] widx, ridx;
    rd_state_t       rstate, rstate_nxt;
    logic            inflight, q_user, q_last;
    logic            first, drop_word, ovf_evt, last_rd, pop;
    logic [1:0]      occ;
    logic [2:0]      level;
    assign line_select = wp;
    assign wr_addr     = widx[ADDR_W-1:0];
    assign rd_select   = rp;
    assign read_addr   = ridx[ADDR_W-1:0];
    assign Tvalid_out  = occ != 2'd0;
    assign pop         = Tvalid_out && Tready;
    // a line that starts while its target buffer is still owned by the reader is dropped whole
    always_comb begin
        first      = widx == '0 && !dropping;
        drop_word  = dropping || (first && (bstate[wp] == BUF_FULL || bstate[wp] == BUF_DRAIN));
        we         = reset && wr_valid && !drop_word && widx < DEPTH_L;
        ovf_evt    = wr_valid && wr_line_end && (drop_word || widx == DEPTH_L);
        level      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
        rd_en      = reset && rstate == RD_STREAM && level < 3'd2;
        last_rd    = ridx == blen[rp] - ONE;
        rstate_nxt = (rstate == RD_IDLE && bstate[rp] == BUF_FULL) ? RD_STREAM :
                     (rstate == RD_STREAM && rd_en && last_rd)      ? RD_FLUSH  :
                     (rstate == RD_FLUSH && inflight && q_last)     ? RD_IDLE   : rstate;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bstate[0]   <= BUF_EMPTY;
            bstate[1]   <= BUF_EMPTY;
            blen[0]     <= '0;
            blen[1]     <= '0;
            sof_flag[0] <= 1'b0;
            sof_flag[1] <= 1'b0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            sof_pending <= 1'b0;
            dropping    <= 1'b0;
            widx        <= '0;
            ridx        <= '0;
            rstate      <= RD_IDLE;
            inflight    <= 1'b0;
            q_user      <= 1'b0;
            q_last      <= 1'b0;
            overflow    <= 1'b0;
            ovf_count   <= '0;
        end else begin
            rstate      <= rstate_nxt;
            inflight    <= rd_en;
            q_user      <= sof_flag[rp] && ridx == '0;
            q_last      <= last_rd;
            sof_pending <= wr_frame_start || (sof_pending && !(wr_valid && !drop_word && first));
            if (wr_valid && drop_word) dropping <= !wr_line_end;
            if (wr_valid && !drop_word) begin
                if (first) sof_flag[wp] <= sof_pending;
                if (wr_line_end) begin
                    bstate[wp] <= BUF_FULL;
                    blen[wp]   <= widx == DEPTH_L ? DEPTH_L : widx + ONE;
                    wp         <= !wp;
                    widx       <= '0;
                end else begin
                    bstate[wp] <= BUF_FILL;
                    if (widx != DEPTH_L) widx <= widx + ONE;
                end
            end
            if (ovf_evt) begin
                overflow <= 1'b1;
                if (ovf_count != '1) ovf_count <= ovf_count + CNT_W'(1);
            end
            if (rstate == RD_IDLE && bstate[rp] == BUF_FULL) begin
                bstate[rp] <= BUF_DRAIN;
                ridx       <= '0;
            end
            if (rd_en) ridx <= ridx + ONE;
            if (rstate == RD_FLUSH && inflight && q_last) begin
                bstate[rp] <= BUF_EMPTY;
                rp         <= !rp;
            end
        end
    end
    csi_skid_fifo #(.W(DATA_W + 2)) u_skid (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .din   ({rd_data, q_user, q_last}),
        .pop   (pop),
        .dout  ({Tdata, Tuser, Tlast}),
        .count (occ)
    );
endmodule

// File: doc/csi_linebuf_ctrl.md
Name: csi_linebuf_ctrl

Overview:
Ping-pong line-buffer controller between the byte-to-pixel stage and the AXI4-Stream output of the CSI receiver.
- Steers packed pixel words into one of two line buffers.
- Tracks the fill/drain state of each buffer.
- Issues read addresses to drain completed lines in order.
- Presents the data on a backpressure-safe AXI4-Stream master: Tuser = start of frame, Tlast = end of line.
- Detects and counts line overflows when both buffers are busy.

Parameters:
- DATA_W, 32, pixel word width.
- ADDR_W, 16, line buffer address width.
- DEPTH, 1024, words per line buffer; DEPTH <= 2^ADDR_W.
- CNT_W, 8, overflow counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr_valid  in  1  pixel word valid from byte-to-pixel.
- wr_line_end  in  1  qualifies the last word of a line; meaningful only when wr_valid=1.
- wr_frame_start  in  1  single-cycle pulse before the first line of a frame.
- we  out  1  line buffer write enable.
- line_select  out  1  buffer being written (0/1).
- wr_addr  out  ADDR_W  write address.
- rd_en  out  1  line buffer read strobe.
- rd_select  out  1  buffer being read.
- read_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  buffer output, valid exactly 1 cycle after rd_en.
- Tready  in  1  downstream ready.
- Tvalid_out  out  1  stream valid.
- Tdata  out  DATA_W  stream data.
- Tuser  out  1  first word of frame.
- Tlast  out  1  last word of line.
- overflow  out  1  sticky; any line dropped or truncated since reset.
- ovf_count  out  CNT_W  dropped/truncated line count; saturates at all-ones.

Behaviour:
- Reset (reset=0 at a clock edge) forces:
  - all outputs to 0;
  - both buffers to EMPTY;
  - write and read pointers to buffer 0;
  - sof_pending and the skid FIFO cleared.
  Applies mid-line or mid-stream; in-flight data is discarded.
- Per-buffer state: EMPTY -> FILL -> FULL -> DRAIN -> EMPTY. Each buffer also stores len[b] (1..DEPTH) and sof[b].

Write side:
- On wr_valid with buffer wp EMPTY or FILL:
  - we=1, line_select=wp, wr_addr = word index; the buffer goes to FILL.
  - First word of the line: sof[wp] <= sof_pending, and sof_pending is cleared.
- On wr_line_end: len[wp] <= index+1, buffer -> FULL, wp toggles.
- Words with index >= DEPTH: we=0 and the word is discarded. At the line end, len=DEPTH; overflow set; ovf_count += 1.
- wr_valid while buffer wp is FULL or DRAIN:
  - we=0, and words are dropped until the line end.
  - At the line end: overflow set, ovf_count += 1; wp does not toggle.
  - sof_pending is preserved for the next accepted line.
- wr_frame_start sets sof_pending.

Read FSM (RD_IDLE, RD_STREAM, RD_FLUSH):
- RD_IDLE: if buffer rp is FULL -> RD_STREAM; buffer -> DRAIN; read_addr <= 0.
- RD_STREAM: issue rd_en (rd_select=rp, read_addr incrementing) whenever skid occupancy + in-flight - pop < 2. After issuing addr len-1 -> RD_FLUSH.
- RD_FLUSH: when the final word enters the skid -> buffer rp EMPTY, rp toggles, -> RD_IDLE.

Skid and stream output:
- 2-entry skid FIFO holds {data, user, last}.
  - user = sof[rp] on word 0.
  - last = 1 on word len-1.
- Tvalid_out = skid non-empty; Tdata, Tuser and Tlast come from the head entry.
- Pop on Tvalid_out & Tready.
- Held stable while Tvalid_out=1 and Tready=0.

Latency and throughput:
- Line end written in cycle N -> FULL at N+1, first rd_en at N+2, Tvalid_out=1 at N+4.
- With Tready held 1, the stream sustains 1 word/cycle with no bubbles inside a line.

Concurrency:
- A write FILL->FULL and a read DRAIN->EMPTY in the same cycle both take effect.
- Writes to one buffer proceed while the other drains.

Decomposition:
- Package csi_pkg holds:
  - buf_state_t enum {BUF_EMPTY, BUF_FILL, BUF_FULL, BUF_DRAIN};
  - rd_state_t enum {RD_IDLE, RD_STREAM, RD_FLUSH};
  - default DEPTH/ADDR_W constants.
- Sub-module csi_skid_fifo: 2-entry synchronous FIFO with occupancy output. The controller FSMs stay in the top module.

Test Plan:
- Single line: wr_frame_start, then 4 words D0..D3 with line_end on D3 in cycle N, Tready=1 -> Tvalid_out rises at N+4.
  - Beats D0..D3 on consecutive cycles, Tuser only on D0, Tlast only on D3.
  - Buffer 0 returns to EMPTY.
- Backpressure: 8-word line with Tready toggling 1,0,0,1,... -> all 8 words delivered in order, no duplicates; Tdata/Tuser/Tlast stable across stalls.
- Ping-pong: three back-to-back 16-word lines, Tready=1 -> lines stream in order, alternating rd_select 0,1,0.
  - Tuser only on the first word of line 1.
  - No gaps within a line.
- Overflow: Tready=0, write three 4-word lines -> lines 1 and 2 buffered, line 3 dropped (we=0), overflow=1, ovf_count=1.
  - Then Tready=1: exactly lines 1 and 2 stream out.
- Truncation: DEPTH=8, 10-word line -> 8 words streamed, Tlast on the 8th, overflow=1, ovf_count=1.
- Reset mid-stream: reset=0 for one cycle during a draining line -> next cycle all outputs 0.
  - A new 2-word line afterwards streams correctly from buffer 0 with Tuser set after wr_frame_start.
